// File: rtl/mem_cmd_seq_if.sv
// rtl/mem_cmd_seq_if.sv - RAM command bus between the sequencer and its RAM
interface mem_cmd_seq_if;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    modport master (
        output ram_addr,
        output ram_we,
        output ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  ram_addr,
        input  ram_we,
        input  ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/mem_cmd_seq.sv
// rtl/mem_cmd_seq.sv - switch-driven RAM write/increment/display command sequencer
module mem_cmd_seq #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2,
    parameter int RD_LAT        = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        sw_data,
    input  logic [9:0]        sw_addr,
    input  logic [1:0]        sw_mode,
    mem_cmd_seq_if.master     ram,
    output logic [15:0]       disp_value,
    output logic              disp_valid,
    output logic              busy
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE, RD_ISSUE, RD_WAIT, WR, RMW_ISSUE, RMW_WAIT, RMW_WR
    } state_t;

    state_t state, state_next;

    logic [15:0]   sync_q [SYNC_STAGES];
    logic [3:0]    s_data;
    logic [9:0]    s_addr;
    logic [1:0]    s_mode;
    logic [1:0]    acc_mode, cand;
    logic [CW-1:0] stab_cnt, run_next;
    logic          accept, trig;
    logic          pend, pend_inc, take;
    logic [WW-1:0] wcnt;
    logic          wait_last;
    logic [9:0]    addr_q;
    logic [15:0]   wdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {sw_mode, sw_addr, sw_data};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s_data = sync_q[SYNC_STAGES-1][3:0];
    assign s_addr = sync_q[SYNC_STAGES-1][13:4];
    assign s_mode = sync_q[SYNC_STAGES-1][15:14];

    // run_next is the length of the current run of one non-accepted mode value
    always_comb begin
        run_next = (s_mode == cand && stab_cnt != '0) ? stab_cnt + CW'(1) : CW'(1);
        accept   = (s_mode != acc_mode) && (run_next == CW'(STABLE_CYCLES));
        trig     = accept && s_mode[1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_mode <= 2'b00;
            cand     <= 2'b00;
            stab_cnt <= '0;
            pend     <= 1'b0;
            pend_inc <= 1'b0;
        end else begin
            if (s_mode == acc_mode) begin
                stab_cnt <= '0;
            end else if (accept) begin
                acc_mode <= s_mode;
                stab_cnt <= '0;
            end else begin
                cand     <= s_mode;
                stab_cnt <= run_next;
            end
            if (trig && (!pend || take)) begin
                pend     <= 1'b1;
                pend_inc <= s_mode[0];
            end else if (take) begin
                pend     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        wait_last  = (wcnt == WW'(RD_LAT - 1));
        case (state)
            IDLE: begin
                if (pend) begin
                    take       = 1'b1;
                    state_next = pend_inc ? RMW_ISSUE : WR;
                end else if (acc_mode == 2'b01) begin
                    state_next = RD_ISSUE;
                end
            end
            RD_ISSUE:  state_next = RD_WAIT;
            RD_WAIT:   if (wait_last) state_next = IDLE;
            WR:        state_next = IDLE;
            RMW_ISSUE: state_next = RMW_WAIT;
            RMW_WAIT:  if (wait_last) state_next = RMW_WR;
            RMW_WR:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Display reads use the live address so a changed address shows up one loop sooner
    assign ram.ram_addr  = (state == RD_ISSUE) ? s_addr : addr_q;
    assign ram.ram_we    = rst_n && (state == WR || state == RMW_WR);
    assign ram.ram_wdata = wdata_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            disp_value <= '0;
            disp_valid <= 1'b0;
            wcnt       <= '0;
        end else begin
            if (take) begin
                addr_q <= s_addr;
                if (!pend_inc) begin
                    wdata_q    <= {12'h000, s_data};
                    disp_value <= {12'h000, s_data};
                    disp_valid <= 1'b1;
                end
            end
            if (state == RD_ISSUE) addr_q <= s_addr;
            if (state == RD_WAIT || state == RMW_WAIT)
                wcnt <= wait_last ? '0 : wcnt + WW'(1);
            else
                wcnt <= '0;
            if (state == RD_WAIT && wait_last) begin
                disp_value <= ram.ram_rdata;
                disp_valid <= 1'b1;
            end
            if (state == RMW_WAIT && wait_last) begin
                wdata_q    <= ram.ram_rdata + 16'd1;
                disp_value <= ram.ram_rdata + 16'd1;
                disp_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_cmd_seq.sv
// tb/tb_mem_cmd_seq.sv - self-checking bench for mem_cmd_seq with a RAM model
module tb_mem_cmd_seq;
    localparam int S = 2;
    localparam int T = 2;
    localparam int L = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  sw_data;
    logic [9:0]  sw_addr;
    logic [1:0]  sw_mode;
    logic [15:0] disp_value;
    logic        disp_valid;
    logic        busy;

    mem_cmd_seq_if ram_if();

    mem_cmd_seq #(.SYNC_STAGES(S), .STABLE_CYCLES(T), .RD_LAT(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_data    (sw_data),
        .sw_addr    (sw_addr),
        .sw_mode    (sw_mode),
        .ram        (ram_if),
        .disp_value (disp_value),
        .disp_valid (disp_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [1024];
    logic [15:0] rd_pipe [L];
    logic        poke_en = 1'b0;
    logic [9:0]  poke_a = '0;
    logic [15:0] poke_d = '0;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_pipe[0] <= mem[ram_if.ram_addr];
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (poke_en)            mem[poke_a] <= poke_d;
        else if (ram_if.ram_we) mem[ram_if.ram_addr] <= ram_if.ram_wdata;
    end
    assign ram_if.ram_rdata = rd_pipe[L-1];

    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          last_cyc = 0;
    logic [9:0]  last_addr = '0;
    logic [15:0] last_wdata = '0;
    logic        prev_we = 1'b0;
    logic        busy_seen = 1'b0;

    always @(negedge clk) begin
        if (ram_if.ram_we === 1'b1) begin
            checks++;
            if (prev_we) begin
                errors++;
                $display("FAIL we_single: ram_we high two cycles running at cycle %0d", cyc);
            end
            wr_cnt++;
            last_addr  = ram_if.ram_addr;
            last_wdata = ram_if.ram_wdata;
            last_cyc   = cyc;
        end
        prev_we = (ram_if.ram_we === 1'b1);
        if (busy === 1'b1) busy_seen = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [9:0] a, input logic [15:0] d);
        poke_en = 1'b1; poke_a = a; poke_d = d;
        tick(1);
        poke_en = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] mode, input int hold, input logic [9:0] a,
                          input logic [3:0] d, output int p);
        sw_addr = a; sw_data = d; sw_mode = 2'b00;
        tick(S + 2);
        sw_mode = mode;
        p = cyc;
        tick(hold);
        sw_mode = 2'b00;
        tick(30);
    endtask

    typedef struct {
        logic [1:0]  mode;
        int          hold;
        logic [9:0]  addr;
        logic [3:0]  data;
        logic [15:0] init;
        int          exp_nw;
        logic [15:0] exp_wdata;
    } vec_t;

    vec_t        vecs [7];
    logic [15:0] ref_mem [1024];
    logic [9:0]  raddr [8];

    initial begin
        int          p, w0, exp_lat, idx, hold;
        logic [1:0]  m;
        logic [3:0]  d;
        logic [15:0] expw;
        logic        got;

        vecs[0] = '{2'b10, 3, 10'd2,    4'h6, 16'h0000, 1, 16'h0006};
        vecs[1] = '{2'b11, 2, 10'd2,    4'h0, 16'h0006, 1, 16'h0007};
        vecs[2] = '{2'b11, 2, 10'd9,    4'h0, 16'hFFFF, 1, 16'h0000};
        vecs[3] = '{2'b10, 1, 10'd4,    4'hA, 16'h1111, 0, 16'h0000};
        vecs[4] = '{2'b11, 1, 10'd4,    4'h0, 16'h1111, 0, 16'h0000};
        vecs[5] = '{2'b10, 4, 10'd1023, 4'hF, 16'h5555, 1, 16'h000F};
        vecs[6] = '{2'b00, 3, 10'd7,    4'h3, 16'h2222, 0, 16'h0000};

        rst_n = 1'b0; sw_data = '0; sw_addr = '0; sw_mode = 2'b00;
        tick(3);
        chk("rst_ram_addr", ram_if.ram_addr, 0);
        chk("rst_ram_we", ram_if.ram_we, 0);
        chk("rst_ram_wdata", ram_if.ram_wdata, 0);
        chk("rst_disp_value", disp_value, 0);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 7; i++) begin
            poke(vecs[i].addr, vecs[i].init);
            w0 = wr_cnt;
            busy_seen = 1'b0;
            run_op(vecs[i].mode, vecs[i].hold, vecs[i].addr, vecs[i].data, p);
            chk($sformatf("vec%0d_writes", i), wr_cnt - w0, vecs[i].exp_nw);
            chk($sformatf("vec%0d_busy_seen", i), busy_seen, vecs[i].exp_nw != 0);
            if (vecs[i].exp_nw != 0) begin
                exp_lat = (vecs[i].mode == 2'b10) ? S + T + 1 : S + T + L + 2;
                chk($sformatf("vec%0d_addr", i), last_addr, vecs[i].addr);
                chk($sformatf("vec%0d_wdata", i), last_wdata, vecs[i].exp_wdata);
                chk($sformatf("vec%0d_latency", i), last_cyc - p, exp_lat);
                chk($sformatf("vec%0d_disp", i), disp_value, vecs[i].exp_wdata);
                chk($sformatf("vec%0d_mem", i), mem[vecs[i].addr], vecs[i].exp_wdata);
            end
        end

        poke(10'd2, 16'h0006);
        for (int n = 0; n < 2; n++) begin
            w0 = wr_cnt;
            run_op(2'b11, 2, 10'd2, 4'h0, p);
            chk($sformatf("inc%0d_writes", n), wr_cnt - w0, 1);
            chk($sformatf("inc%0d_wdata", n), last_wdata, 16'h0007 + 16'(n));
            chk($sformatf("inc%0d_latency", n), last_cyc - p, S + T + L + 2);
        end

        poke(10'd2, 16'h1234);
        poke(10'd5, 16'hBEEF);
        sw_addr = 10'd2;
        tick(S + 2);
        sw_mode = 2'b01;
        tick(20);
        chk("disp_addr2", disp_value, 16'h1234);
        chk("disp_valid_rd", disp_valid, 1);
        sw_addr = 10'd5;
        got = 1'b0;
        for (int k = 0; k < L + S + 3 && !got; k++) begin
            tick(1);
            if (disp_value == 16'hBEEF) got = 1'b1;
        end
        chk("disp_follow_addr5", disp_value, 16'hBEEF);
        sw_mode = 2'b00;
        tick(10);
        chk("disp_idle_busy", busy, 0);

        poke(10'd2, 16'h0000);
        sw_addr = 10'd2; sw_data = 4'h6; sw_mode = 2'b01;
        tick(15);
        w0 = wr_cnt;
        sw_mode = 2'b10;
        tick(3);
        sw_mode = 2'b01;
        tick(20);
        chk("wr01_writes", wr_cnt - w0, 1);
        chk("wr01_addr", last_addr, 10'd2);
        chk("wr01_wdata", last_wdata, 16'h0006);
        chk("wr01_disp", disp_value, 16'h0006);
        sw_mode = 2'b00;
        tick(10);

        for (int i = 0; i < 8; i++) begin
            raddr[i] = 10'(100 + i * 7);
            ref_mem[raddr[i]] = 16'($urandom);
            if (i == 0) ref_mem[raddr[i]] = 16'hFFFE;
            poke(raddr[i], ref_mem[raddr[i]]);
        end
        for (int r = 0; r < 40; r++) begin
            idx  = $urandom_range(0, 7);
            m    = 2'($urandom_range(2, 3));
            hold = $urandom_range(1, 4);
            d    = 4'($urandom);
            expw = (m == 2'b10) ? {12'h000, d} : ref_mem[raddr[idx]] + 16'd1;
            w0 = wr_cnt;
            run_op(m, hold, raddr[idx], d, p);
            chk($sformatf("rnd%0d_writes", r), wr_cnt - w0, (hold >= T) ? 1 : 0);
            if (hold >= T) begin
                ref_mem[raddr[idx]] = expw;
                chk($sformatf("rnd%0d_addr", r), last_addr, raddr[idx]);
                chk($sformatf("rnd%0d_wdata", r), last_wdata, expw);
            end
        end
        for (int i = 0; i < 8; i++)
            chk($sformatf("rnd_mem%0d", i), mem[raddr[i]], ref_mem[raddr[i]]);

        poke(10'd3, 16'h00AA);
        sw_addr = 10'd3;
        tick(S + 2);
        sw_mode = 2'b11;
        tick(S + T + 2);
        chk("rmw_wait_busy", busy, 1);
        w0 = wr_cnt;
        rst_n = 1'b0;
        sw_mode = 2'b00;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_addr", ram_if.ram_addr, 0);
        chk("post_rst_wdata", ram_if.ram_wdata, 0);
        chk("post_rst_disp", disp_value, 0);
        chk("post_rst_valid", disp_valid, 0);
        chk("post_rst_busy", busy, 0);
        tick(15);
        chk("post_rst_no_write", wr_cnt - w0, 0);
        chk("post_rst_idle", busy, 0);
        chk("post_rst_mem", mem[10'd3], 16'h00AA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
